id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/branches_pkg.sv | 13 +
 rtl/lx32_pkg.sv | 23 ++
 rtl/operand_fwd.sv | 34 +++
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/branches_pkg.sv
// Branch comparison encodings shared by decode, execute and the branch unit.
package branches_pkg;

  typedef enum logic [2:0] {
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE,
    BR_LTU,
    BR_GEU
  } branch_op_e;

endpackage

// File: rtl/lx32_pkg.sv
// Shared core types: ALU operation encoding and operand-forwarding source select.
package lx32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd.sv
// Priority operand bypass: MEM result beats WB result beats register-file data.
module operand_fwd
  import lx32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       rs_i,
  input  logic [WIDTH-1:0] reg_data_i,
  input  logic             mem_valid_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [WIDTH-1:0] mem_data_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0] value_o,
  output fwd_sel_e         sel_o
);

  always_comb begin
    sel_o   = FWD_REG;
    value_o = reg_data_i;
    // x0 is hard-wired, so it never takes a bypassed value.
    if (rs_i != 5'd0) begin
      if (mem_valid_i && (mem_rd_i == rs_i)) begin
        sel_o   = FWD_MEM;
        value_o = mem_data_i;
      end else if (wb_valid_i && (wb_rd_i == rs_i)) begin
        sel_o   = FWD_WB;
        value_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush and operand bypass.
module id_ex_stage
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  alu_op_e          id_alu_control,
  input  branch_op_e       id_branch_op,
  input  logic             id_is_branch,
  input  logic             id_use_imm,
  input  logic             id_reg_write,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             fwd_mem_valid,
  input  logic             fwd_wb_valid,
  input  logic [4:0]       fwd_mem_rd,
  input  logic [4:0]       fwd_wb_rd,
  input  logic [WIDTH-1:0] fwd_mem_data,
  input  logic [WIDTH-1:0] fwd_wb_data,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] ex_store_data,
  output alu_op_e          ex_alu_control,
  output branch_op_e       ex_branch_op,
  output logic             ex_is_branch,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  alu_op_e          alu_q, alu_d;
  branch_op_e       br_q, br_d;
  logic             is_branch_q, is_branch_d, use_imm_q, use_imm_d, reg_write_q, reg_write_d;

  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;
  fwd_sel_e         rs1_sel, rs2_sel;
  logic             transfer;

  assign id_ready = !valid_q || ex_ready;
  assign transfer = id_valid && id_ready && !flush;

  operand_fwd #(.WIDTH(WIDTH)) u_fwd_rs1 (
    .rs_i        (rs1_q),
    .reg_data_i  (rs1_data_q),
    .mem_valid_i (fwd_mem_valid),
    .mem_rd_i    (fwd_mem_rd),
    .mem_data_i  (fwd_mem_data),
    .wb_valid_i  (fwd_wb_valid),
    .wb_rd_i     (fwd_wb_rd),
    .wb_data_i   (fwd_wb_data),
    .value_o     (rs1_fwd),
    .sel_o       (rs1_sel)
  );

  operand_fwd #(.WIDTH(WIDTH)) u_fwd_rs2 (
    .rs_i        (rs2_q),
    .reg_data_i  (rs2_data_q),
    .mem_valid_i (fwd_mem_valid),
    .mem_rd_i    (fwd_mem_rd),
    .mem_data_i  (fwd_mem_data),
    .wb_valid_i  (fwd_wb_valid),
    .wb_rd_i     (fwd_wb_rd),
    .wb_data_i   (fwd_wb_data),
    .value_o     (rs2_fwd),
    .sel_o       (rs2_sel)
  );

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    br_d        = br_q;
    is_branch_d = is_branch_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (transfer) begin
      valid_d     = 1'b1;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      alu_d       = id_alu_control;
      br_d        = id_branch_op;
      is_branch_d = id_is_branch;
      use_imm_d   = id_use_imm;
      reg_write_d = id_reg_write;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Capture bypassed operands while stalled; the producer may retire before we issue.
      if (rs1_sel != FWD_REG) rs1_data_d = rs1_fwd;
      if (rs2_sel != FWD_REG) rs2_data_d = rs2_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_q       <= ALU_ADD;
      br_q        <= BR_EQ;
      is_branch_q <= 1'b0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      br_q        <= br_d;
      is_branch_q <= is_branch_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign src_a          = rs1_fwd;
  assign src_b          = use_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data  = rs2_fwd;
  assign ex_alu_control = alu_q;
  assign ex_branch_op   = br_q;
  assign ex_is_branch   = is_branch_q && valid_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = reg_write_q && valid_q;

endmodule
